// File: rtl/dlx_pkg.sv
// Shared DLX constants: ALU codes, opcodes/funcs, instruction field positions
// and the ID/EX bundle types.
package dlx_pkg;

    localparam logic [0:3] ALU_ADD = 4'b0000;
    localparam logic [0:3] ALU_SUB = 4'b0001;
    localparam logic [0:3] ALU_SLT = 4'b0010;
    localparam logic [0:3] ALU_SLE = 4'b0011;
    localparam logic [0:3] ALU_SGT = 4'b0100;
    localparam logic [0:3] ALU_SGE = 4'b0101;
    localparam logic [0:3] ALU_SRA = 4'b0111;
    localparam logic [0:3] ALU_SLL = 4'b1001;
    localparam logic [0:3] ALU_SRL = 4'b1010;
    localparam logic [0:3] ALU_SEQ = 4'b1011;
    localparam logic [0:3] ALU_SNE = 4'b1100;
    localparam logic [0:3] ALU_AND = 4'b1101;
    localparam logic [0:3] ALU_OR  = 4'b1110;
    localparam logic [0:3] ALU_XOR = 4'b1111;

    localparam logic [0:5] OP_RTYPE = 6'h00;
    localparam logic [0:5] OP_ADDI  = 6'h08;
    localparam logic [0:5] OP_ADDUI = 6'h09;
    localparam logic [0:5] OP_SUBI  = 6'h0A;
    localparam logic [0:5] OP_SUBUI = 6'h0B;
    localparam logic [0:5] OP_ANDI  = 6'h0C;
    localparam logic [0:5] OP_ORI   = 6'h0D;
    localparam logic [0:5] OP_XORI  = 6'h0E;
    localparam logic [0:5] OP_LHI   = 6'h0F;
    localparam logic [0:5] OP_SLLI  = 6'h14;
    localparam logic [0:5] OP_SRLI  = 6'h16;
    localparam logic [0:5] OP_SRAI  = 6'h17;
    localparam logic [0:5] OP_SEQI  = 6'h18;
    localparam logic [0:5] OP_SNEI  = 6'h19;
    localparam logic [0:5] OP_SLTI  = 6'h1A;
    localparam logic [0:5] OP_SGTI  = 6'h1B;
    localparam logic [0:5] OP_SLEI  = 6'h1C;
    localparam logic [0:5] OP_SGEI  = 6'h1D;
    localparam logic [0:5] OP_LW    = 6'h23;
    localparam logic [0:5] OP_SW    = 6'h2B;

    localparam logic [0:5] FN_SLL  = 6'h04;
    localparam logic [0:5] FN_SRL  = 6'h06;
    localparam logic [0:5] FN_SRA  = 6'h07;
    localparam logic [0:5] FN_ADD  = 6'h20;
    localparam logic [0:5] FN_ADDU = 6'h21;
    localparam logic [0:5] FN_SUB  = 6'h22;
    localparam logic [0:5] FN_SUBU = 6'h23;
    localparam logic [0:5] FN_AND  = 6'h24;
    localparam logic [0:5] FN_OR   = 6'h25;
    localparam logic [0:5] FN_XOR  = 6'h26;
    localparam logic [0:5] FN_SEQ  = 6'h28;
    localparam logic [0:5] FN_SNE  = 6'h29;
    localparam logic [0:5] FN_SLT  = 6'h2A;
    localparam logic [0:5] FN_SGT  = 6'h2B;
    localparam logic [0:5] FN_SLE  = 6'h2C;
    localparam logic [0:5] FN_SGE  = 6'h2D;

    localparam int OP_POS  = 0;
    localparam int RS1_POS = 6;
    localparam int RS2_POS = 11;
    localparam int RD_POS  = 16;
    localparam int FN_POS  = 26;
    localparam int IMM_POS = 16;

    typedef enum logic [2:0] {
        B_RS2,
        B_SEXT,
        B_ZEXT,
        B_LHI,
        B_ZERO
    } bsel_e;

    typedef struct packed {
        logic [0:3] ctrl;
        bsel_e      bsel;
        logic       a_zero;
        logic [0:4] rd;
        logic       wr_en;
        logic       illegal;
    } dec_t;

    typedef struct packed {
        logic [0:31] a;
        logic [0:31] b;
        logic [0:3]  ctrl;
        logic [0:4]  rd;
        logic        wr_en;
        logic        illegal;
    } id_ex_t;

    typedef enum logic {
        EMPTY,
        FULL
    } st_e;

endpackage

// File: rtl/dlx_ex_issue_if.sv
// Upstream issue and downstream ALU handshake bundle of the ID/EX stage.
interface dlx_ex_issue_if;

    logic        in_valid;
    logic        in_ready;
    logic [0:31] instr;
    logic [0:31] rs1_val;
    logic [0:31] rs2_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] alu_a;
    logic [0:31] alu_b;
    logic [0:3]  alu_ctrl;
    logic [0:4]  rd;
    logic        wr_en;
    logic        illegal;

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, wr_en,
        illegal
    );

    modport master (
        output in_valid, instr, rs1_val, rs2_val, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, wr_en,
        illegal
    );

endinterface

// File: rtl/dlx_alu_decode.sv
// Combinational DLX decoder: ALU code, operand-B source, rd, writeback
// enable and illegal flag.
module dlx_alu_decode
    import dlx_pkg::*;
(
    input  logic [0:31] instr_i,
    output dec_t        dec_o
);

    logic [0:5] op;
    logic [0:5] fn;
    logic [0:3] ctrl;
    bsel_e      bsel;
    logic       legal;
    logic       wr;
    logic [0:4] rd;
    logic       unused_fields;

    assign op = instr_i[OP_POS +: 6];
    assign fn = instr_i[FN_POS +: 6];
    assign unused_fields = ^{instr_i[RS1_POS +: 5], instr_i[21:25]};

    always_comb begin
        ctrl  = ALU_ADD;
        bsel  = B_SEXT;
        legal = 1'b1;
        wr    = 1'b1;
        rd    = instr_i[RS2_POS +: 5];
        unique case (op)
            OP_RTYPE: begin
                bsel = B_RS2;
                rd   = instr_i[RD_POS +: 5];
                unique case (fn)
                    FN_SLL:          ctrl = ALU_SLL;
                    FN_SRL:          ctrl = ALU_SRL;
                    FN_SRA:          ctrl = ALU_SRA;
                    FN_ADD, FN_ADDU: ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl = ALU_SUB;
                    FN_AND:          ctrl = ALU_AND;
                    FN_OR:           ctrl = ALU_OR;
                    FN_XOR:          ctrl = ALU_XOR;
                    FN_SEQ:          ctrl = ALU_SEQ;
                    FN_SNE:          ctrl = ALU_SNE;
                    FN_SLT:          ctrl = ALU_SLT;
                    FN_SGT:          ctrl = ALU_SGT;
                    FN_SLE:          ctrl = ALU_SLE;
                    FN_SGE:          ctrl = ALU_SGE;
                    default:         legal = 1'b0;
                endcase
            end
            OP_ADDI:  ctrl = ALU_ADD;
            OP_ADDUI: bsel = B_ZEXT;
            OP_SUBI:  ctrl = ALU_SUB;
            OP_SUBUI: begin ctrl = ALU_SUB; bsel = B_ZEXT; end
            OP_ANDI:  begin ctrl = ALU_AND; bsel = B_ZEXT; end
            OP_ORI:   begin ctrl = ALU_OR;  bsel = B_ZEXT; end
            OP_XORI:  begin ctrl = ALU_XOR; bsel = B_ZEXT; end
            OP_LHI:   bsel = B_LHI;
            OP_SLLI:  begin ctrl = ALU_SLL; bsel = B_ZEXT; end
            OP_SRLI:  begin ctrl = ALU_SRL; bsel = B_ZEXT; end
            OP_SRAI:  begin ctrl = ALU_SRA; bsel = B_ZEXT; end
            OP_SEQI:  ctrl = ALU_SEQ;
            OP_SNEI:  ctrl = ALU_SNE;
            OP_SLTI:  ctrl = ALU_SLT;
            OP_SGTI:  ctrl = ALU_SGT;
            OP_SLEI:  ctrl = ALU_SLE;
            OP_SGEI:  ctrl = ALU_SGE;
            OP_LW:    ctrl = ALU_ADD;
            OP_SW:    begin wr = 1'b0; rd = 5'd0; end
            default:  legal = 1'b0;
        endcase
    end

    // Illegal entries still issue, but as a harmless zero-operand ADD.
    always_comb begin
        dec_o.ctrl    = legal ? ctrl : ALU_ADD;
        dec_o.bsel    = legal ? bsel : B_ZERO;
        dec_o.a_zero  = !legal || (op == OP_LHI);
        dec_o.rd      = legal ? rd : 5'd0;
        dec_o.wr_en   = legal && wr && (rd != 5'd0);
        dec_o.illegal = !legal;
    end

endmodule

// File: rtl/dlx_ex_issue.sv
// ID/EX issue stage: decode, operand mux and a one-entry valid/ready
// pipeline register feeding the DLX ALU.
module dlx_ex_issue
    import dlx_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    dlx_ex_issue_if.slave bus
);

    dec_t        dec;
    logic [0:15] imm;
    id_ex_t      nxt;
    id_ex_t      data_d;
    id_ex_t      data_q;
    st_e         state_d;
    st_e         state_q;
    logic        accept;

    dlx_alu_decode u_dec (
        .instr_i (bus.instr),
        .dec_o   (dec)
    );

    assign imm = bus.instr[IMM_POS +: 16];

    always_comb begin
        nxt.a       = dec.a_zero ? 32'd0 : bus.rs1_val;
        nxt.ctrl    = dec.ctrl;
        nxt.rd      = dec.rd;
        nxt.wr_en   = dec.wr_en;
        nxt.illegal = dec.illegal;
        unique case (dec.bsel)
            B_RS2:   nxt.b = bus.rs2_val;
            B_SEXT:  nxt.b = {{16{imm[0]}}, imm};
            B_ZEXT:  nxt.b = {16'h0000, imm};
            B_LHI:   nxt.b = {imm, 16'h0000};
            default: nxt.b = 32'd0;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over both drain and a same-cycle accept.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
    end

    assign data_d = (accept && !bus.flush) ? nxt : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.alu_a    = data_q.a;
    assign bus.alu_b    = data_q.b;
    assign bus.alu_ctrl = data_q.ctrl;
    assign bus.rd       = data_q.rd;
    assign bus.wr_en    = data_q.wr_en;
    assign bus.illegal  = data_q.illegal;

endmodule

// File: tb/tb_dlx_ex_issue.sv
// Directed bench for dlx_ex_issue with a reference decoder and an in-order
// scoreboard of issued entries.
module tb_dlx_ex_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   pushes;
    int   pops;
    exp_t sb[$];

    dlx_ex_issue_if bus ();

    dlx_ex_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs1, input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs1, rd, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs1, rs2, rd, 5'h00, fn};
    endfunction

    function automatic exp_t model(input logic [31:0] ins,
        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [5:0]  op;
        logic [15:0] imm;
        logic        z;
        logic        ok;
        op  = ins[31:26];
        imm = ins[15:0];
        e   = '0;
        z   = 1'b0;
        ok  = 1'b1;
        if (op == 6'h00) begin
            case (ins[5:0])
                6'h04: e.c = 4'h9;
                6'h06: e.c = 4'hA;
                6'h07: e.c = 4'h7;
                6'h20, 6'h21: e.c = 4'h0;
                6'h22, 6'h23: e.c = 4'h1;
                6'h24: e.c = 4'hD;
                6'h25: e.c = 4'hE;
                6'h26: e.c = 4'hF;
                6'h28: e.c = 4'hB;
                6'h29: e.c = 4'hC;
                6'h2A: e.c = 4'h2;
                6'h2B: e.c = 4'h4;
                6'h2C: e.c = 4'h3;
                6'h2D: e.c = 4'h5;
                default: ok = 1'b0;
            endcase
            if (ok) begin
                e.a = r1; e.b = r2; e.rd = ins[15:11]; e.wr = 1'b1;
            end
        end else if (op == 6'h0F) begin
            e.b = {imm, 16'h0000}; e.rd = ins[20:16]; e.wr = 1'b1;
        end else begin
            case (op)
                6'h08, 6'h23, 6'h2B: e.c = 4'h0;
                6'h09: begin e.c = 4'h0; z = 1'b1; end
                6'h0A: e.c = 4'h1;
                6'h0B: begin e.c = 4'h1; z = 1'b1; end
                6'h0C: begin e.c = 4'hD; z = 1'b1; end
                6'h0D: begin e.c = 4'hE; z = 1'b1; end
                6'h0E: begin e.c = 4'hF; z = 1'b1; end
                6'h14: begin e.c = 4'h9; z = 1'b1; end
                6'h16: begin e.c = 4'hA; z = 1'b1; end
                6'h17: begin e.c = 4'h7; z = 1'b1; end
                6'h18: e.c = 4'hB;
                6'h19: e.c = 4'hC;
                6'h1A: e.c = 4'h2;
                6'h1B: e.c = 4'h4;
                6'h1C: e.c = 4'h3;
                6'h1D: e.c = 4'h5;
                default: ok = 1'b0;
            endcase
            if (ok) begin
                e.a  = r1;
                e.b  = z ? {16'h0000, imm} : {{16{imm[15]}}, imm};
                e.rd = (op == 6'h2B) ? 5'd0 : ins[20:16];
                e.wr = (op != 6'h2B);
            end
        end
        e.ill = !ok;
        if (e.rd == 5'd0) e.wr = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    chk("sb_pending", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        pops++;
                        chk("sb_alu_a", bus.alu_a, e.a);
                        chk("sb_alu_b", bus.alu_b, e.b);
                        chk("sb_ctrl", 32'(bus.alu_ctrl), 32'(e.c));
                        chk("sb_rd", 32'(bus.rd), 32'(e.rd));
                        chk("sb_wr_en", 32'(bus.wr_en), 32'(e.wr));
                        chk("sb_illegal", 32'(bus.illegal), 32'(e.ill));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    sb.push_back(model(bus.instr, bus.rs1_val, bus.rs2_val));
                    pushes++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_val  = r1;
        bus.rs2_val  = r2;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tbl [8];
        logic [31:0] snap_a;
        logic [31:0] snap_b;
        logic [3:0]  snap_c;
        errors = 0; checks = 0; pushes = 0; pops = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.rs1_val = '0;
        bus.rs2_val = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        issue(32'h2023FFFF, 32'd5, 32'd77);
        chk("addi_valid", 32'(bus.out_valid), 1);
        chk("addi_a", bus.alu_a, 32'h00000005);
        chk("addi_b", bus.alu_b, 32'hFFFFFFFF);
        chk("addi_ctrl", 32'(bus.alu_ctrl), 32'h0);
        chk("addi_rd", 32'(bus.rd), 3);
        chk("addi_wr", 32'(bus.wr_en), 1);

        issue(32'h00222022, 32'd10, 32'h0000ABCD);
        chk("sub_ctrl", 32'(bus.alu_ctrl), 32'h1);
        chk("sub_b", bus.alu_b, 32'h0000ABCD);
        chk("sub_rd", 32'(bus.rd), 4);

        issue(32'h34058000, 32'd7, 32'd0);
        chk("ori_b", bus.alu_b, 32'h00008000);
        chk("ori_ctrl", 32'(bus.alu_ctrl), 32'hE);
        chk("ori_rd", 32'(bus.rd), 5);

        issue(32'h3C061234, 32'd99, 32'd1);
        chk("lhi_a", bus.alu_a, 32'h00000000);
        chk("lhi_b", bus.alu_b, 32'h12340000);
        chk("lhi_ctrl", 32'(bus.alu_ctrl), 32'h0);

        issue(32'hFC000000, 32'd3, 32'd4);
        chk("ill_flag", 32'(bus.illegal), 1);
        chk("ill_wr", 32'(bus.wr_en), 0);
        chk("ill_a", bus.alu_a, 0);

        issue(rtype(5'd1, 5'd2, 5'd0, 6'h20), 32'd8, 32'd9);
        chk("r0_wr", 32'(bus.wr_en), 0);
        chk("r0_valid", 32'(bus.out_valid), 1);

        // Stall with a new instruction waiting upstream.
        snap_a = bus.alu_a; snap_b = bus.alu_b; snap_c = bus.alu_ctrl;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = itype(6'h0E, 5'd4, 5'd2, 16'hF0F0);
        bus.rs1_val   = 32'h13572468;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            step();
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_a", bus.alu_a, snap_a);
            chk("bp_b", bus.alu_b, snap_b);
            chk("bp_ctrl", 32'(bus.alu_ctrl), 32'(snap_c));
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bp_release_b", bus.alu_b, 32'h0000F0F0);

        tbl[0] = itype(6'h17, 5'd2, 5'd7, 16'h0003);
        tbl[1] = itype(6'h1C, 5'd1, 5'd8, 16'h8001);
        tbl[2] = rtype(5'd3, 5'd4, 5'd9, 6'h2A);
        tbl[3] = itype(6'h23, 5'd5, 5'd10, 16'hFFF0);
        tbl[4] = itype(6'h2B, 5'd5, 5'd11, 16'h0010);
        tbl[5] = itype(6'h0E, 5'd6, 5'd12, 16'hF0F0);
        tbl[6] = rtype(5'd1, 5'd2, 5'd13, 6'h3F);
        tbl[7] = itype(6'h09, 5'd0, 5'd14, 16'hFFFF);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.instr   = tbl[i];
            bus.rs1_val = $urandom;
            bus.rs2_val = $urandom;
            step();
            chk("b2b_valid", 32'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 0);
        chk("push_pop", 32'(pops), 32'(pushes));

        issue(32'h2023FFFF, 32'd1, 32'd0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.instr    = 32'h00222022;
        step();
        chk("flush_valid", 32'(bus.out_valid), 0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("flush_dropped", 32'(bus.out_valid), 0);

        issue(32'h2023FFFF, 32'h0BADF00D, 32'd0);
        chk("pre_rst_a", bus.alu_a, 32'h0BADF00D);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("async_valid", 32'(bus.out_valid), 0);
        chk("async_a", bus.alu_a, 0);
        chk("async_b", bus.alu_b, 0);
        chk("async_rd", 32'(bus.rd), 0);
        chk("async_wr", 32'(bus.wr_en), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlx_ex_issue.md
# dlx_ex_issue

Registered ID/EX issue stage directly upstream of the 32-bit DLX ALU. Decodes one instruction word and its register-file operand values into ALU operand A, operand B and the 4-bit ALU control code. Holds them in a single pipeline register with a valid/ready handshake, so the ALU and downstream stages see stable, aligned operands. Uses MSB-first bit numbering ([0:31], bit 0 = MSB), the same as the ALU.

## Interface
- No parameters. Widths are fixed by the DLX ISA: data 32 bits, register index 5 bits, ALU ctrl 4 bits.
- Clock and reset are fixed for this block: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr, rs1_val and rs2_val are valid this cycle
- in_ready  out  1  stage accepts input this cycle
- instr  in  [0:31]  instruction word; opcode [0:5], rs1 [6:10], rs2 [11:15], R-rd [16:20], func [26:31], imm16 [16:31]
- rs1_val  in  [0:31]  register-file value of rs1
- rs2_val  in  [0:31]  register-file value of rs2
- flush  in  1  discard the held entry (branch or exception)
- out_valid  out  1  registered outputs are valid
- out_ready  in  1  ALU/EX consumer accepts this cycle
- alu_a  out  [0:31]  ALU operand A
- alu_b  out  [0:31]  ALU operand B
- alu_ctrl  out  [0:3]  ALU function code
- rd  out  [0:4]  writeback register index
- wr_en  out  1  result is written back to rd
- illegal  out  1  undecodable opcode or func

## Operation
- ALU codes: ADD 0000, SUB 0001, SLT 0010, SLE 0011, SGT 0100, SGE 0101, SRA 0111, SLL 1001, SRL 1010, SEQ 1011, SNE 1100, AND 1101, OR 1110, XOR 1111.
- R-type (opcode 0x00), func → code:
  - sll 0x04, srl 0x06, sra 0x07
  - add/addu 0x20/0x21, sub/subu 0x22/0x23
  - and 0x24, or 0x25, xor 0x26
  - seq 0x28, sne 0x29, slt 0x2A, sgt 0x2B, sle 0x2C, sge 0x2D
  - Operands: A = rs1_val, B = rs2_val, rd = instr[16:20].
- I-type, opcode → code:
  - addi 08, addui 09, subi 0A, subui 0B
  - andi 0C, ori 0D, xori 0E
  - slli 14, srli 16, srai 17
  - seqi 18, snei 19, slti 1A, sgti 1B, slei 1C, sgei 1D
  - Operands: A = rs1_val, B = extended imm16, rd = instr[11:15].
- Immediate extension:
  - Zero-extend for addui, subui, andi, ori, xori and the shifts.
  - Sign-extend for all other I-type opcodes.
- lhi 0x0F: A = 0, B = {imm16, 16'h0000}, ctrl ADD.
- lw 0x23: ctrl ADD, B = sign-extended imm16, wr_en = 1.
- sw 0x2B: ctrl ADD, B = sign-extended imm16, wr_en = 0, rd = 0.
- Writes to r0 are suppressed: wr_en = 0 whenever rd == 0.
- Any other opcode or func is illegal:
  - Entry still issues with illegal = 1, wr_en = 0, ctrl ADD, A = B = 0.
  - Downstream raises the trap.
- State: register EMPTY (out_valid = 0) / FULL (out_valid = 1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on out_ready without a new accept.
  - FULL → FULL on simultaneous drain + accept.

## Timing
- Reset (asynchronous, immediate): out_valid = 0. alu_a, alu_b, alu_ctrl, rd, wr_en and illegal = 0.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of one instruction per cycle.
- Accept happens when in_valid && in_ready. Outputs update on the next rising edge; latency is 1 cycle.
- While out_valid && !out_ready, all outputs hold bit-stable.
- flush has priority. The next edge forces out_valid = 0, and any input accepted in the same cycle is dropped. Data fields may keep stale values.
- Reset asserted mid-transfer clears the stage. No partial entry survives.

## Structure
- Package dlx_pkg holds:
  - the ALU code localparams (shared with alu)
  - opcode/func localparams
  - field position constants
- One combinational sub-module, dlx_alu_decode: instr → ctrl, imm select, extension type, rd, wr_en, illegal. The top level holds the operand mux and handshake register.

## Test plan
- addi r3,r1,-1: instr 0x2023FFFF, rs1_val 5 → next cycle alu_a 00000005, alu_b FFFFFFFF, ctrl 0000, rd 3, wr_en 1.
- sub r4,r1,r2: instr 0x00222022 → ctrl 0001, alu_b = rs2_val, rd 4. ori r5,r0,0x8000: instr 0x34058000 → alu_b 00008000, ctrl 1110.
- lhi r6,0x1234: instr 0x3C061234 → alu_a 00000000, alu_b 12340000, ctrl 0000.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with out_valid = 1 → in_ready 0 and outputs unchanged.
  - Then back-to-back issue at 1/cycle with no loss or duplication.
- Illegal and r0 cases:
  - instr 0xFC000000 → illegal 1, wr_en 0.
  - add r0,r1,r2 → wr_en 0.
- Flush/reset:
  - flush with in_valid high → out_valid 0 next cycle.
  - rst_n pulsed low between edges → outputs zero immediately.
